// File: rtl/mux_sel_pkg.sv
// Shared types and defaults for the mux select controller and its dwell counter.
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam int DWELL_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 8;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/mux_sel_ctrl_dwell_counter.sv
// Ownership dwell timer: loads 1 when a new owner is granted, counts up while
// the grant is held and saturates at DWELL, where done stays asserted.
module dwell_counter
  import mux_sel_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [7:0] DWELL_MAX = 8'(DWELL);

  logic [7:0] dwell_q;
  logic [7:0] dwell_d;

  always_comb begin
    dwell_d = dwell_q;
    if (load) begin
      dwell_d = 8'd1;
    end else if (en && (dwell_q < DWELL_MAX)) begin
      dwell_d = dwell_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= 8'd0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign done = (dwell_q == DWELL_MAX);

endmodule

// File: rtl/mux_sel_ctrl.sv
// Two-source select controller for a 2:1 mux: round-robin on contention,
// minimum dwell per owner, registered sel/grant_valid and a wrapping switch counter.
module mux_sel_ctrl
  import mux_sel_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  output logic             sel,
  output logic             grant_valid,
  output logic [CNT_W-1:0] switch_count
);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             grant_valid_q, grant_valid_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] switch_count_q, switch_count_d;

  logic grant_en;
  logic grant_to;
  logic dwell_load;
  logic dwell_en;
  logic dwell_done;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .load(dwell_load),
    .en  (dwell_en),
    .done(dwell_done)
  );

  // Exits from an owned state are only considered once the dwell has saturated.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    grant_valid_d = grant_valid_q;
    last_owner_d  = last_owner_q;
    grant_en      = 1'b0;
    grant_to      = OWNER_A;

    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || (last_owner_q == OWNER_B))) begin
          grant_en = 1'b1;
          grant_to = OWNER_A;
        end else if (req_b) begin
          grant_en = 1'b1;
          grant_to = OWNER_B;
        end
      end
      OWN_A: begin
        if (dwell_done) begin
          if (req_b) begin
            grant_en = 1'b1;
            grant_to = OWNER_B;
          end else if (!req_a) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
          end
        end
      end
      OWN_B: begin
        if (dwell_done) begin
          if (req_a) begin
            grant_en = 1'b1;
            grant_to = OWNER_A;
          end else if (!req_b) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase

    if (grant_en) begin
      state_d       = (grant_to == OWNER_B) ? OWN_B : OWN_A;
      sel_d         = grant_to;
      grant_valid_d = 1'b1;
      last_owner_d  = grant_to;
    end

    switch_count_d = switch_count_q + CNT_W'(sel_d ^ sel_q);
  end

  assign dwell_load = grant_en;
  assign dwell_en   = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sel_q          <= 1'b0;
      grant_valid_q  <= 1'b0;
      last_owner_q   <= OWNER_B;
      switch_count_q <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      grant_valid_q  <= grant_valid_d;
      last_owner_q   <= last_owner_d;
      switch_count_q <= switch_count_d;
    end
  end

  assign sel          = sel_q;
  assign grant_valid  = grant_valid_q;
  assign switch_count = switch_count_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed vector bench for mux_sel_ctrl; a second instance with a 2-bit
// switch counter shares the same stimulus to exercise counter wrap.
module tb_mux_sel_ctrl;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic       sel;
  logic       grant_valid;
  logic [7:0] switch_count;
  logic       sel_w;
  logic       grant_valid_w;
  logic [1:0] switch_count_w;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic rst;
    logic req_a;
    logic req_b;
    logic exp_sel;
    logic exp_gv;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[$];

  mux_sel_ctrl #(
    .DWELL(4),
    .CNT_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a       (req_a),
    .req_b       (req_b),
    .sel         (sel),
    .grant_valid (grant_valid),
    .switch_count(switch_count)
  );

  mux_sel_ctrl #(
    .DWELL(4),
    .CNT_W(2)
  ) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .req_a       (req_a),
    .req_b       (req_b),
    .sel         (sel_w),
    .grant_valid (grant_valid_w),
    .switch_count(switch_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic a, input logic b,
                        input logic s, input logic g, input int c);
    vec_t v;
    v.rst = r;
    v.req_a = a;
    v.req_b = b;
    v.exp_sel = s;
    v.exp_gv = g;
    v.exp_cnt = c;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic a, input logic b);
    @(negedge clk);
    rst   = r;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input int idx, input int got, input int want);
    testsRun++;
    if (got != want) begin
      testsFailed++;
      $display("[TB] FAIL %s[%0d]: got %0d, want %0d", name, idx, got, want);
    end
  endtask

  task automatic checkOutput(input int idx, input logic es, input logic eg, input int ec);
    checkVal("sel", idx, int'(sel), int'(es));
    checkVal("grant_valid", idx, int'(grant_valid), int'(eg));
    checkVal("switch_count", idx, int'(switch_count), ec % 256);
    checkVal("sel_wrapinst", idx, int'(sel_w), int'(es));
    checkVal("switch_count_wrap", idx, int'(switch_count_w), ec % 4);
  endtask

  initial begin
    int edges;
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;

    // Reset with both requests high, then A wins the first tie.
    addVec(1, 1, 1, 0, 0, 0);
    addVec(1, 1, 1, 0, 0, 0);
    addVec(0, 1, 1, 0, 1, 0);
    // Both held: A keeps the grant for the full dwell, then strict alternation.
    addVec(0, 1, 1, 0, 1, 0);
    addVec(0, 1, 1, 0, 1, 0);
    addVec(0, 1, 1, 0, 1, 0);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        addVec(0, 1, 1, (r % 2 == 0) ? 1'b1 : 1'b0, 1, r + 1);
      end
    end
    addVec(0, 1, 1, 1, 1, 5);
    // B releases: grant holds until dwell expires, then IDLE with sel held.
    addVec(0, 0, 0, 1, 1, 5);
    addVec(0, 0, 0, 1, 1, 5);
    addVec(0, 0, 0, 1, 1, 5);
    addVec(0, 0, 0, 1, 0, 5);
    addVec(0, 0, 0, 1, 0, 5);
    // A alone, dropped after one cycle: four cycles of grant then IDLE.
    addVec(0, 1, 0, 0, 1, 6);
    addVec(0, 0, 0, 0, 1, 6);
    addVec(0, 0, 0, 0, 1, 6);
    addVec(0, 0, 0, 0, 1, 6);
    addVec(0, 0, 0, 0, 0, 6);
    // Later B request switches sel one cycle later.
    addVec(0, 0, 1, 1, 1, 7);
    addVec(0, 0, 1, 1, 1, 7);
    // Reset mid-ownership of B, then a tie grants A again.
    addVec(1, 1, 1, 0, 0, 0);
    addVec(0, 1, 1, 0, 1, 0);
    addVec(0, 1, 0, 0, 1, 0);
    addVec(0, 1, 0, 0, 1, 0);
    addVec(0, 1, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0);
    // Tie in IDLE after A owned goes to B.
    addVec(0, 1, 1, 1, 1, 1);
    // B alone beyond the dwell stays put with the dwell saturated.
    addVec(0, 0, 1, 1, 1, 1);
    addVec(0, 0, 1, 1, 1, 1);
    addVec(0, 0, 1, 1, 1, 1);
    addVec(0, 0, 1, 1, 1, 1);
    addVec(0, 0, 1, 1, 1, 1);
    addVec(0, 1, 1, 0, 1, 2);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req_a, vecs[i].req_b);
      checkOutput(i, vecs[i].exp_sel, vecs[i].exp_gv, vecs[i].exp_cnt);
    end

    // A just granted; with no requests it must hold the grant exactly 4 edges.
    edges = 0;
    while (grant_valid === 1'b1 && edges < 12) begin
      applyStimulus(0, 0, 0);
      edges++;
    end
    checkVal("release_edges", 0, edges, 4);
    checkOutput(1000, 0, 0, 2);

    // Grant latency from IDLE is one edge.
    applyStimulus(0, 0, 1);
    checkOutput(1001, 1, 1, 3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
